fre_track: RTL and testbench

- Downstream stage of the pulse-width measurement block. It consumes that block's filtered 16-bit count output.
- Samples the count on every value change, or periodically if the value is stable, and keeps a power-of-two moving average.
- Reports the signed error of the average against a nominal count.
- Runs a lock/loss state machine with consecutive-hit qualification. The lock flag gates downstream symbol-timing logic.

---
 rtl/fre_track_if.sv | 29 ++
 rtl/fre_track.sv | 167 ++++++++++++++++
 tb/tb_fre_track.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fre_track_if.sv
// fre_track_if: signals between the pulse-width measurement stage, fre_track
// and its consumers.
//   cnt_in    16  filtered count from the measurement stage
//   avg_out   16  moving average of sampled counts
//   avg_valid  1  one-cycle pulse on a full-window average update
//   err_out   17  signed avg_out - nominal count
//   locked     1  tracker is locked to the nominal count
//   min_out   16  min sampled count while locked (optional feature)
//   max_out   16  max sampled count while locked (optional feature)
// master: producer of cnt_in / consumer of results; slave: fre_track itself.
interface fre_track_if;
  logic        [15:0] cnt_in;
  logic        [15:0] avg_out;
  logic               avg_valid;
  logic signed [16:0] err_out;
  logic               locked;
  logic        [15:0] min_out;
  logic        [15:0] max_out;

  modport master (
    output cnt_in,
    input  avg_out, avg_valid, err_out, locked, min_out, max_out
  );

  modport slave (
    input  cnt_in,
    output avg_out, avg_valid, err_out, locked, min_out, max_out
  );
endinterface

// File: rtl/fre_track.sv
// fre_track: frequency tracker behind the pulse-width measurement block.
// Samples the count whenever it changes (or after HOLD_CYC stable cycles),
// keeps a 2^WIN_LOG2-deep moving average, reports the signed error against
// NOM_CNT and runs a lock/loss FSM with consecutive-hit qualification.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  fre_track_if.slave (cnt_in in; avg_out, avg_valid, err_out,
//        locked, min_out, max_out out)
// Optional feature: define FRE_TRACK_MINMAX_EN to track min/max sampled
// counts while locked; otherwise min_out/max_out are tied to 0.
//
// state  | meaning
// S_FILL | window not yet full, waiting for the first valid average
// S_ACQ  | counting consecutive hits towards lock
// S_LOCK | locked, counting consecutive misses towards loss
module fre_track #(
  parameter int WIN_LOG2 = 3,
  parameter int NOM_CNT  = 917,
  parameter int LOCK_TOL = 16,
  parameter int LOCK_CNT = 4,
  parameter int LOST_CNT = 3,
  parameter int HOLD_CYC = 2048
) (
  input logic        clk,
  input logic        rst,
  fre_track_if.slave bus
);
  localparam int WIN    = 1 << WIN_LOG2;
  localparam int SUM_W  = 16 + WIN_LOG2;
  localparam int HOLD_W = $clog2(HOLD_CYC);
  localparam int HC_W   = $clog2(LOCK_CNT + 1);
  localparam int MC_W   = $clog2(LOST_CNT + 1);

  typedef enum logic [1:0] {S_FILL, S_ACQ, S_LOCK} state_t;

  logic        [15:0]       r_cnt_q;
  logic        [15:0]       r_last_smp;
  logic        [15:0]       r_buf [WIN];
  logic        [WIN_LOG2-1:0] r_wr_ptr;
  logic        [SUM_W-1:0]  r_sum;
  logic        [WIN_LOG2:0] r_fill;
  logic        [HOLD_W-1:0] r_hold;
  logic                     r_sum_full;
  logic        [15:0]       r_avg;
  logic signed [16:0]       r_err;
  logic                     r_valid;
  state_t                   r_state;
  logic        [HC_W-1:0]   r_hit_cnt;
  logic        [MC_W-1:0]   r_miss_cnt;
  logic                     r_locked;

  logic        w_smp;
  logic        w_hit;
  logic        w_lock_entry;
  logic [15:0] w_avg;
  logic [16:0] w_err_abs;

  // A change and a hold timeout in the same cycle still give a single sample.
  assign w_smp = (r_cnt_q != r_last_smp) || (r_hold == HOLD_W'(HOLD_CYC - 1));
  assign w_avg = r_sum[WIN_LOG2 +: 16];
  assign w_err_abs = r_err[16] ? (~r_err + 17'd1) : r_err;
  assign w_hit = (w_err_abs <= 17'(LOCK_TOL));
  assign w_lock_entry = r_valid && w_hit && (r_state != S_LOCK) &&
                        (r_hit_cnt == HC_W'(LOCK_CNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_q    <= '0;
      r_last_smp <= '0;
      for (int i = 0; i < WIN; i++) r_buf[i] <= '0;
      r_wr_ptr   <= '0;
      r_sum      <= '0;
      r_fill     <= '0;
      r_hold     <= '0;
      r_sum_full <= 1'b0;
      r_avg      <= '0;
      r_err      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_cnt_q    <= bus.cnt_in;
      r_sum_full <= 1'b0;
      if (w_smp) begin
        r_buf[r_wr_ptr] <= r_cnt_q;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        // Evicted entry is still 0 while the window is filling.
        r_sum      <= r_sum + SUM_W'(r_cnt_q) - SUM_W'(r_buf[r_wr_ptr]);
        r_last_smp <= r_cnt_q;
        r_hold     <= '0;
        if (r_fill != (WIN_LOG2 + 1)'(WIN)) r_fill <= r_fill + 1'b1;
        r_sum_full <= (r_fill >= (WIN_LOG2 + 1)'(WIN - 1));
      end else begin
        r_hold <= r_hold + 1'b1;
      end
      r_valid <= r_sum_full;
      if (r_sum_full) begin
        r_avg <= w_avg;
        r_err <= 17'($signed({1'b0, w_avg}) - NOM_CNT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (r_valid) begin
      case (r_state)
        S_FILL, S_ACQ: begin
          if (w_lock_entry) begin
            r_state   <= S_LOCK;
            r_hit_cnt <= '0;
            r_locked  <= 1'b1;
          end else begin
            r_state   <= S_ACQ;
            r_hit_cnt <= w_hit ? r_hit_cnt + 1'b1 : '0;
          end
        end
        S_LOCK: begin
          if (w_hit) begin
            r_miss_cnt <= '0;
          end else if (r_miss_cnt == MC_W'(LOST_CNT - 1)) begin
            r_state    <= S_ACQ;
            r_miss_cnt <= '0;
            r_hit_cnt  <= '0;
            r_locked   <= 1'b0;
          end else begin
            r_miss_cnt <= r_miss_cnt + 1'b1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign bus.avg_out   = r_avg;
  assign bus.avg_valid = r_valid;
  assign bus.err_out   = r_err;
  assign bus.locked    = r_locked;

`ifdef FRE_TRACK_MINMAX_EN
  logic [15:0] r_min;
  logic [15:0] r_max;

  // Entry load wins over a sample landing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min <= '0;
      r_max <= '0;
    end else if (w_lock_entry) begin
      r_min <= r_avg;
      r_max <= r_avg;
    end else if ((r_state == S_LOCK) && w_smp) begin
      if (r_cnt_q < r_min) r_min <= r_cnt_q;
      if (r_cnt_q > r_max) r_max <= r_cnt_q;
    end
  end

  assign bus.min_out = r_min;
  assign bus.max_out = r_max;
`else
  assign bus.min_out = '0;
  assign bus.max_out = '0;
`endif
endmodule

// File: tb/tb_fre_track.sv
module tb_fre_track;
  typedef struct {
    logic [15:0] cnt;
    bit          rst_before;
    int          exp_avg;
    int          exp_err;
    int          exp_pulses;
    bit          exp_locked;
    bit          chk_mm;
    int          exp_min;
    int          exp_max;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  fre_track_if bus();

  fre_track dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] cnt, input bit r, input int a,
                              input int e, input int p, input bit l,
                              input bit m, input int mn, input int mx);
    vec_t v;
    v.cnt = cnt; v.rst_before = r; v.exp_avg = a; v.exp_err = e;
    v.exp_pulses = p; v.exp_locked = l; v.chk_mm = m; v.exp_min = mn; v.exp_max = mx;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    int pulses;
    pulses = 0;
    if (v.rst_before) begin
      rst = 1'b1;
      step();
      chk({tag, " rst avg"}, bus.avg_out, 0);
      chk({tag, " rst err"}, $signed(bus.err_out), 0);
      chk({tag, " rst valid"}, bus.avg_valid, 0);
      chk({tag, " rst locked"}, bus.locked, 0);
      rst = 1'b0;
    end
    bus.cnt_in = v.cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.avg_valid) pulses++;
    end
    chk({tag, " pulses"}, pulses, v.exp_pulses);
    chk({tag, " avg"}, bus.avg_out, v.exp_avg);
    chk({tag, " err"}, $signed(bus.err_out), v.exp_err);
    chk({tag, " locked"}, bus.locked, int'(v.exp_locked));
`ifdef FRE_TRACK_MINMAX_EN
    if (v.chk_mm) begin
      chk({tag, " min"}, bus.min_out, v.exp_min);
      chk({tag, " max"}, bus.max_out, v.exp_max);
    end
`else
    chk({tag, " min"}, bus.min_out, 0);
    chk({tag, " max"}, bus.max_out, 0);
`endif
  endtask

  vec_t va [16];
  vec_t vb [18];

  initial begin
    int c, pulses, wide, last_pulse;
    bit prev_v;

    // Averaging exactness (900..907), then loss of lock with a hit between misses.
    va[0]  = mk(900,  0, 914,  -3, 1, 1, 0, 0, 0);
    va[1]  = mk(901,  0, 912,  -5, 1, 1, 0, 0, 0);
    va[2]  = mk(902,  0, 911,  -6, 1, 1, 0, 0, 0);
    va[3]  = mk(903,  0, 909,  -8, 1, 1, 0, 0, 0);
    va[4]  = mk(904,  0, 907, -10, 1, 1, 0, 0, 0);
    va[5]  = mk(905,  0, 906, -11, 1, 1, 0, 0, 0);
    va[6]  = mk(906,  0, 904, -13, 1, 1, 0, 0, 0);
    va[7]  = mk(907,  0, 903, -14, 1, 1, 0, 0, 0);
    va[8]  = mk(1000, 0, 916,  -1, 1, 1, 0, 0, 0);
    va[9]  = mk(1001, 0, 928,  11, 1, 1, 0, 0, 0);
    va[10] = mk(1000, 0, 940,  23, 1, 1, 0, 0, 0);
    va[11] = mk(1001, 0, 953,  36, 1, 1, 0, 0, 0);
    va[12] = mk(700,  0, 927,  10, 1, 1, 0, 0, 0);
    va[13] = mk(1000, 0, 939,  22, 1, 1, 0, 0, 0);
    va[14] = mk(1001, 0, 951,  34, 1, 1, 0, 0, 0);
    va[15] = mk(1000, 0, 962,  45, 1, 0, 0, 0, 0);

    // Reset mid-fill, fresh fill, relock and min/max tracking.
    vb[0]  = mk(500, 1, 0,   0, 0, 0, 0, 0, 0);
    vb[1]  = mk(501, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[2]  = mk(502, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[3]  = mk(503, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[4]  = mk(504, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[5]  = mk(920, 1, 0,   0, 0, 0, 0, 0, 0);
    vb[6]  = mk(921, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[7]  = mk(922, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[8]  = mk(923, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[9]  = mk(924, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[10] = mk(925, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[11] = mk(926, 0, 0,   0, 0, 0, 0, 0, 0);
    vb[12] = mk(927, 0, 923, 6, 1, 0, 0, 0, 0);
    vb[13] = mk(917, 0, 923, 6, 1, 0, 0, 0, 0);
    vb[14] = mk(918, 0, 922, 5, 1, 0, 0, 0, 0);
    vb[15] = mk(917, 0, 922, 5, 1, 1, 1, 922, 922);
    vb[16] = mk(910, 0, 920, 3, 1, 1, 1, 910, 922);
    vb[17] = mk(925, 0, 920, 3, 1, 1, 1, 910, 925);

    // Reset state
    bus.cnt_in = 917;
    rst = 1'b1;
    repeat (3) step();
    chk("reset avg", bus.avg_out, 0);
    chk("reset err", $signed(bus.err_out), 0);
    chk("reset valid", bus.avg_valid, 0);
    chk("reset locked", bus.locked, 0);
    chk("reset min", bus.min_out, 0);
    chk("reset max", bus.max_out, 0);
    rst = 1'b0;

    // Stable 917: samples every 2048 cycles, first valid after 8th sample.
    c = 0;
    while (c < 30000) begin
      step();
      c++;
      if (bus.avg_valid) break;
    end
    chk("first valid cycle", c, 14339);
    chk("first valid avg", bus.avg_out, 917);
    chk("first valid err", $signed(bus.err_out), 0);

    pulses = 1; wide = 0; last_pulse = c; prev_v = 1'b1;
    while (c < 30000 && !bus.locked) begin
      step();
      c++;
      if (bus.avg_valid) begin
        pulses++;
        last_pulse = c;
        if (prev_v) wide++;
      end
      prev_v = bus.avg_valid;
    end
    chk("lock cycle", c, 20484);
    chk("lock pulses", pulses, 4);
    chk("lock after pulse", c - last_pulse, 1);
    chk("valid width", wide, 0);

    for (int i = 0; i < 16; i++) apply(va[i], $sformatf("va%0d", i));

    // Change lands on the cycle hold reaches HOLD_CYC-1: one sample only.
    repeat (2038) step();
    bus.cnt_in = 1200;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.avg_valid) pulses++;
    end
    chk("simul pulses", pulses, 1);
    chk("simul avg", bus.avg_out, 987);
    chk("simul err", $signed(bus.err_out), 70);
    chk("simul locked", bus.locked, 0);

    for (int i = 0; i < 18; i++) apply(vb[i], $sformatf("vb%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
